// File: rtl/seg_effect_pkg.sv
// Shared constants for the seven-segment effect engine: mode encoding,
// default effect-step dividers and the blank segment pattern.
package seg_effect_pkg;

  typedef enum logic [1:0] {
    MODE_STATIC = 2'd0,
    MODE_BLINK  = 2'd1,
    MODE_REVEAL = 2'd2,
    MODE_SCROLL = 2'd3
  } mode_e;

  localparam int unsigned TICK_DIV0_DEF = 50000000;
  localparam int unsigned TICK_DIV1_DEF = 25000000;
  localparam int unsigned TICK_DIV2_DEF = 12500000;
  localparam int unsigned TICK_DIV3_DEF = 6250000;

  localparam int unsigned SEG_W     = 7;
  localparam logic [6:0]  SEG_BLANK = 7'h7F;

  // Largest of the four step dividers, used to size the tick counter.
  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/seg_effect_divider.sv
// Terminal-count counter: counts 0..i_limit-1 and flags the last count.
// i_clr holds the count at zero and suppresses the terminal flag.
module seg_effect_divider #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic [WIDTH-1:0] i_limit,
  output logic             o_tc_c
);

  logic [WIDTH-1:0] r_cnt;
  logic             w_last;

  // >= so that a smaller limit takes effect without finishing the old period
  assign w_last = (r_cnt >= (i_limit - WIDTH'(1)));
  assign o_tc_c = w_last & ~i_clr;

  always_ff @(posedge clk) begin
    if (rst || i_clr) begin
      r_cnt <= '0;
    end else if (w_last) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + WIDTH'(1);
    end
  end

endmodule

// File: rtl/seg_effect_engine.sv
// Multiplexed 7-segment driver with static/blink/reveal/scroll effects.
// Define SEG_EFFECT_SCROLL_EN to build scroll mode; otherwise mode 3 acts as static.
module seg_effect_engine
  import seg_effect_pkg::*;
#(
  parameter int unsigned NUM_DIGITS = 7,
  parameter int unsigned SCAN_DIV   = 25000,
  parameter int unsigned TICK_DIV0  = TICK_DIV0_DEF,
  parameter int unsigned TICK_DIV1  = TICK_DIV1_DEF,
  parameter int unsigned TICK_DIV2  = TICK_DIV2_DEF,
  parameter int unsigned TICK_DIV3  = TICK_DIV3_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic [1:0]            mode,
  input  logic [1:0]            freq_sel,
  input  logic                  wr_en,
  input  logic [3:0]            wr_addr,
  input  logic [6:0]            wr_data,
  output logic [NUM_DIGITS-1:0] trans,
  output logic [6:0]            led7seg,
  output logic                  frame_done
);

  localparam int unsigned IDX_W    = $clog2(NUM_DIGITS);
  localparam int unsigned STEP_W   = $clog2(NUM_DIGITS + 2);
  localparam int unsigned SCAN_W   = $clog2(SCAN_DIV + 1);
  localparam int unsigned TICK_MAX = max4(TICK_DIV0, TICK_DIV1, TICK_DIV2, TICK_DIV3);
  localparam int unsigned TICK_W   = $clog2(TICK_MAX + 1);

  mode_e                 w_mode;
  mode_e                 r_mode;
  logic                  w_mode_chg;
  logic                  w_scan_clr;
  logic                  w_tick_clr;
  logic                  w_scan_tc;
  logic                  w_tick_tc;
  logic [TICK_W-1:0]     w_tick_limit;
  logic [STEP_W-1:0]     w_step_last;
  logic                  w_step_wrap;
  logic [IDX_W-1:0]      r_scan_idx;
  logic [STEP_W-1:0]     r_step;
  logic                  r_frame_done;
  logic [SEG_W-1:0]      r_buf [NUM_DIGITS];
  logic                  w_wr_ok;
  logic [SEG_W-1:0]      w_seg;
  logic [NUM_DIGITS-1:0] w_sel_n;
  logic [NUM_DIGITS-1:0] r_trans;
  logic [SEG_W-1:0]      r_led;

  assign w_mode     = mode_e'(mode);
  assign w_mode_chg = (w_mode != r_mode);
  assign w_scan_clr = ~enable;
  assign w_tick_clr = ~enable | w_mode_chg;

  seg_effect_divider #(.WIDTH(SCAN_W)) u_scan_div (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_scan_clr),
    .i_limit (SCAN_W'(SCAN_DIV)),
    .o_tc_c  (w_scan_tc)
  );

  seg_effect_divider #(.WIDTH(TICK_W)) u_tick_div (
    .clk     (clk),
    .rst     (rst),
    .i_clr   (w_tick_clr),
    .i_limit (w_tick_limit),
    .o_tc_c  (w_tick_tc)
  );

  always_comb begin
    w_tick_limit = TICK_W'(TICK_DIV0);
    case (freq_sel)
      2'd1:    w_tick_limit = TICK_W'(TICK_DIV1);
      2'd2:    w_tick_limit = TICK_W'(TICK_DIV2);
      2'd3:    w_tick_limit = TICK_W'(TICK_DIV3);
      default: w_tick_limit = TICK_W'(TICK_DIV0);
    endcase
  end

  // Last step value before the step counter wraps back to 0.
  always_comb begin
    w_step_last = '0;
    case (w_mode)
      MODE_BLINK:  w_step_last = STEP_W'(1);
      MODE_REVEAL: w_step_last = STEP_W'(NUM_DIGITS);
`ifdef SEG_EFFECT_SCROLL_EN
      MODE_SCROLL: w_step_last = STEP_W'(NUM_DIGITS - 1);
`endif
      default:     w_step_last = '0;
    endcase
  end

  assign w_step_wrap = (r_step >= w_step_last);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_mode       <= MODE_STATIC;
      r_scan_idx   <= '0;
      r_step       <= '0;
      r_frame_done <= 1'b0;
    end else begin
      r_mode       <= w_mode;
      r_frame_done <= w_tick_tc & w_step_wrap;
      if (!enable) begin
        r_scan_idx <= '0;
      end else if (w_scan_tc) begin
        r_scan_idx <= (r_scan_idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : r_scan_idx + IDX_W'(1);
      end
      if (!enable || w_mode_chg) begin
        r_step <= '0;
      end else if (w_tick_tc) begin
        r_step <= w_step_wrap ? '0 : r_step + STEP_W'(1);
      end
    end
  end

  // Out-of-range addresses are dropped; writes are taken even while disabled.
  assign w_wr_ok = wr_en && ({1'b0, wr_addr} < 5'(NUM_DIGITS));

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_DIGITS; i++) r_buf[i] <= SEG_BLANK;
    end else if (w_wr_ok) begin
      r_buf[wr_addr[IDX_W-1:0]] <= wr_data;
    end
  end

`ifdef SEG_EFFECT_SCROLL_EN
  localparam int unsigned ROT_W = IDX_W + 1;
  logic [ROT_W-1:0] w_rot_sum;
  logic [IDX_W-1:0] w_rot_idx;

  always_comb begin
    w_rot_sum = ROT_W'(r_scan_idx) + ROT_W'(r_step);
    w_rot_idx = (w_rot_sum >= ROT_W'(NUM_DIGITS)) ? IDX_W'(w_rot_sum - ROT_W'(NUM_DIGITS))
                                                  : IDX_W'(w_rot_sum);
  end
`endif

  always_comb begin
    w_seg = r_buf[r_scan_idx];
    case (w_mode)
      MODE_BLINK:  if (r_step == '0) w_seg = SEG_BLANK;
      MODE_REVEAL: if (STEP_W'(r_scan_idx) >= r_step) w_seg = SEG_BLANK;
`ifdef SEG_EFFECT_SCROLL_EN
      MODE_SCROLL: w_seg = r_buf[w_rot_idx];
`endif
      default:     ;
    endcase
  end

  // Digit 0 drives the most significant select bit.
  always_comb begin
    w_sel_n = '1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (r_scan_idx == IDX_W'(i)) w_sel_n[NUM_DIGITS-1-i] = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || !enable) begin
      r_trans <= '1;
      r_led   <= SEG_BLANK;
    end else begin
      r_trans <= w_sel_n;
      r_led   <= w_seg;
    end
  end

  assign trans      = r_trans;
  assign led7seg    = r_led;
  assign frame_done = r_frame_done;

endmodule

// File: tb/tb_seg_effect_engine.sv
// Directed bench for seg_effect_engine with 4 digits, scan 4, step dividers 16/8/4/2.
module tb_seg_effect_engine;

  localparam int unsigned ND = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic [1:0]    mode;
  logic [1:0]    freq_sel;
  logic          wr_en;
  logic [3:0]    wr_addr;
  logic [6:0]    wr_data;
  logic [ND-1:0] trans;
  logic [6:0]    led7seg;
  logic          frame_done;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  seg_effect_engine #(
    .NUM_DIGITS (ND),
    .SCAN_DIV   (4),
    .TICK_DIV0  (16),
    .TICK_DIV1  (8),
    .TICK_DIV2  (4),
    .TICK_DIV3  (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .enable     (enable),
    .mode       (mode),
    .freq_sel   (freq_sel),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .trans      (trans),
    .led7seg    (led7seg),
    .frame_done (frame_done)
  );

  logic [6:0] bufv     [4]  = '{7'h40, 7'h79, 7'h24, 7'h30};
  logic [3:0] sel_n    [4]  = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};
  logic [6:0] blink_led[9]  = '{7'h7F, 7'h7F, 7'h7F, 7'h40, 7'h79, 7'h7F, 7'h7F, 7'h79, 7'h24};
  logic       blink_fd [9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
`ifdef SEG_EFFECT_SCROLL_EN
  logic [6:0] scr_led  [8]  = '{7'h40, 7'h40, 7'h79, 7'h79, 7'h30, 7'h30, 7'h40, 7'h40};
  logic       scr_fd   [8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
`else
  logic [6:0] scr_led  [8]  = '{7'h40, 7'h40, 7'h40, 7'h40, 7'h79, 7'h79, 7'h79, 7'h79};
  logic       scr_fd   [8]  = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
`endif
  logic [6:0] rev_led  [22] = '{7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F,
                                7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40, 7'h40, 7'h40, 7'h40,
                                7'h79, 7'h79, 7'h79, 7'h79, 7'h24, 7'h7F};

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; mode = 2'd0; freq_sel = 2'd0;
    wr_en = 1'b0; wr_addr = 4'd0; wr_data = 7'd0;
    step(); step();
    chk("rst_trans", 32'(trans), 32'hF);
    chk("rst_led", 32'(led7seg), 32'h7F);
    chk("rst_fd", 32'(frame_done), 32'd0);

    // Load buffer while disabled, plus an out-of-range write
    rst = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_addr = 4'(i); wr_data = bufv[i];
      step();
    end
    wr_addr = 4'd9; wr_data = 7'h00;
    step();
    wr_en = 1'b0;
    chk("dis_trans", 32'(trans), 32'hF);
    chk("dis_led", 32'(led7seg), 32'h7F);

    // Static scan
    enable = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      step();
      chk($sformatf("static_trans%0d", k), 32'(trans), 32'(sel_n[(k-1)/4]));
      chk($sformatf("static_led%0d", k), 32'(led7seg), 32'(bufv[(k-1)/4]));
      chk($sformatf("static_fd%0d", k), 32'(frame_done), 32'(k == 16));
    end

    // Blink entered by mode change, scan keeps running
    mode = 2'd1; freq_sel = 2'd3;
    for (int k = 1; k <= 9; k++) begin
      step();
      chk($sformatf("blink_trans%0d", k), 32'(trans), 32'(sel_n[(k-1)/4]));
      chk($sformatf("blink_led%0d", k), 32'(led7seg), 32'(blink_led[k-1]));
      chk($sformatf("blink_fd%0d", k), 32'(frame_done), 32'(blink_fd[k-1]));
    end

    // Scroll (static when not built in), realigned by a disable cycle
    enable = 1'b0; mode = 2'd3; freq_sel = 2'd3;
    step();
    chk("scr_dis_trans", 32'(trans), 32'hF);
    enable = 1'b1;
    for (int k = 1; k <= 8; k++) begin
      step();
      chk($sformatf("scr_trans%0d", k), 32'(trans), 32'(sel_n[(k-1)/4]));
      chk($sformatf("scr_led%0d", k), 32'(led7seg), 32'(scr_led[k-1]));
      chk($sformatf("scr_fd%0d", k), 32'(frame_done), 32'(scr_fd[k-1]));
    end

    // Reveal, started one digit slot into the scan
    enable = 1'b0; mode = 2'd0; freq_sel = 2'd2;
    step();
    chk("rev_dis_led", 32'(led7seg), 32'h7F);
    enable = 1'b1;
    repeat (4) step();
    chk("rev_pre_led", 32'(led7seg), 32'h40);
    chk("rev_pre_fd", 32'(frame_done), 32'd1);
    mode = 2'd2;
    for (int k = 1; k <= 22; k++) begin
      step();
      chk($sformatf("rev_trans%0d", k), 32'(trans), 32'(sel_n[((k-1)/4 + 1) % 4]));
      chk($sformatf("rev_led%0d", k), 32'(led7seg), 32'(rev_led[k-1]));
      chk($sformatf("rev_fd%0d", k), 32'(frame_done), 32'(k == 21));
    end

    // Reset at reveal step 3 beats enable, write and mode change
    repeat (11) step();
    rst = 1'b1; enable = 1'b1; wr_en = 1'b1; wr_addr = 4'd0; wr_data = 7'h00; mode = 2'd3;
    step();
    chk("midrst_trans", 32'(trans), 32'hF);
    chk("midrst_led", 32'(led7seg), 32'h7F);
    chk("midrst_fd", 32'(frame_done), 32'd0);
    rst = 1'b0; wr_en = 1'b0; mode = 2'd0;
    step();
    chk("post_trans", 32'(trans), 32'h7);
    chk("post_led", 32'(led7seg), 32'h7F);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
